// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: op codes, NZCV bit positions, FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_XOR  = 4'd2,
    OP_NOR  = 4'd3,
    OP_ADD  = 4'd4,
    OP_SUB  = 4'd6,
    OP_SLT  = 4'd7,
    OP_SLTU = 4'd8,
    OP_SLL  = 4'd9,
    OP_SRL  = 4'd10,
    OP_SRA  = 4'd11,
    OP_NOT  = 4'd12
  } alu_op_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // 5 and 13..15 are holes in the op-code map
  function automatic logic op_is_valid(input logic [3:0] op);
    return !((op == 4'd5) || (op >= 4'd13));
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one external ALU through a 3-state IDLE/EXEC/RESP FSM.
// Define ALU_ARBITER_BUSY_CNT_EN to add the saturating busy_cnt output.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_ctrl,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_ctrl,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [N-1:0] resp_result,
  output logic [3:0]   resp_flags,
  output logic         resp_err,
  output logic [3:0]   alu_ctrl,
  output logic [N-1:0] src_A,
  output logic [N-1:0] src_B,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic [3:0]   flags_q
`ifdef ALU_ARBITER_BUSY_CNT_EN
  ,
  output logic [15:0]  busy_cnt
`endif
);

  state_e       state_q, state_d;
  logic [3:0]   ctrl_q, ctrl_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic         last_q, last_d, gid_q, gid_d;
  logic         rid_q, rid_d, rerr_q, rerr_d;
  logic [N-1:0] rres_q, rres_d;
  logic [3:0]   rflg_q, rflg_d, flags_d;
  logic [1:0]   gnt;

  rr_arb2 u_arb (
    .req  ({req1_valid, req0_valid}),
    .last (last_q),
    .gnt  (gnt)
  );

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    a_d     = a_q;
    b_d     = b_q;
    last_d  = last_q;
    gid_d   = gid_q;
    rid_d   = rid_q;
    rerr_d  = rerr_q;
    rres_d  = rres_q;
    rflg_d  = rflg_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE: if (|gnt) begin
        ctrl_d  = gnt[1] ? req1_ctrl : req0_ctrl;
        a_d     = gnt[1] ? req1_a    : req0_a;
        b_d     = gnt[1] ? req1_b    : req0_b;
        last_d  = gnt[1];
        gid_d   = gnt[1];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        rid_d   = gid_q;
        rerr_d  = !op_is_valid(ctrl_q);
        rres_d  = op_is_valid(ctrl_q) ? alu_result : '0;
        rflg_d  = op_is_valid(ctrl_q) ? alu_flags  : 4'h0;
        state_d = S_RESP;
      end
      S_RESP: if (resp_ready) begin
        if (!rerr_q) flags_d = rflg_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      last_q  <= 1'b1;
      gid_q   <= 1'b0;
      rid_q   <= 1'b0;
      rerr_q  <= 1'b0;
      rres_q  <= '0;
      rflg_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      rid_q   <= rid_d;
      rerr_q  <= rerr_d;
      rres_q  <= rres_d;
      rflg_q  <= rflg_d;
      flags_q <= flags_d;
    end
  end

  // ready is a one-cycle grant strobe, forced low while reset is held
  assign req0_ready  = rst_n && (state_q == S_IDLE) && gnt[0];
  assign req1_ready  = rst_n && (state_q == S_IDLE) && gnt[1];
  assign resp_valid  = (state_q == S_RESP);
  assign resp_id     = rid_q;
  assign resp_result = rres_q;
  assign resp_flags  = rflg_q;
  assign resp_err    = rerr_q;
  assign alu_ctrl    = ctrl_q;
  assign src_A       = a_q;
  assign src_B       = b_q;

`ifdef ALU_ARBITER_BUSY_CNT_EN
  logic [15:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if ((state_q != S_IDLE) && (busy_q != 16'hFFFF)) busy_d = busy_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_cnt = busy_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the shared port.
module tb_alu_arbiter;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]   req0_ctrl, req1_ctrl;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         resp_valid, resp_ready, resp_id, resp_err;
  logic [N-1:0] resp_result, src_A, src_B, alu_result;
  logic [3:0]   resp_flags, alu_ctrl, alu_flags, flags_q;
`ifdef ALU_ARBITER_BUSY_CNT_EN
  logic [15:0]  busy_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_flags(resp_flags), .resp_err(resp_err),
    .alu_ctrl(alu_ctrl), .src_A(src_A), .src_B(src_B),
    .alu_result(alu_result), .alu_flags(alu_flags), .flags_q(flags_q)
`ifdef ALU_ARBITER_BUSY_CNT_EN
    , .busy_cnt(busy_cnt)
`endif
  );

  // external ALU: ADD/SUB/AND/OR modelled, anything else returns junk to expose leaks
  always_comb begin
    logic [N:0] t;
    t          = '0;
    alu_result = 32'hDEAD_BEEF;
    alu_flags  = 4'hF;
    case (alu_ctrl)
      4'd0, 4'd1, 4'd4, 4'd6: begin
        case (alu_ctrl)
          4'd0:    t = {1'b0, src_A & src_B};
          4'd1:    t = {1'b0, src_A | src_B};
          4'd4:    t = {1'b0, src_A} + {1'b0, src_B};
          default: t = {(src_A >= src_B), src_A - src_B};
        endcase
        alu_result = t[N-1:0];
        alu_flags[3] = (t[N-1:0] == '0);
        alu_flags[2] = t[N-1];
        alu_flags[1] = (alu_ctrl == 4'd4 || alu_ctrl == 4'd6) ? t[N] : 1'b0;
        alu_flags[0] = (alu_ctrl == 4'd4) ? ((src_A[N-1] == src_B[N-1]) && (t[N-1] != src_A[N-1])) :
                       (alu_ctrl == 4'd6) ? ((src_A[N-1] != src_B[N-1]) && (t[N-1] != src_A[N-1])) : 1'b0;
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; resp_ready = 1'b1;
    req0_valid = 0; req0_ctrl = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_ctrl = 0; req1_a = 0; req1_b = 0;
    nxt(); nxt();
    req0_valid = 1'b1; #1;
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_flags", flags_q, 0);
    chk("rst_srcA", src_A, 0);
    req0_valid = 1'b0;
    nxt(); rst_n = 1'b1;

    // single request
    nxt(); req0_valid = 1; req0_ctrl = 4'd4; req0_a = 5; req0_b = 7; #1;
    chk("t1_rdy0", req0_ready, 1);
    chk("t1_rdy1", req1_ready, 0);
    nxt(); req0_valid = 0; #1;
    chk("t1_exec_rdy0", req0_ready, 0);
    chk("t1_exec_valid", resp_valid, 0);
    chk("t1_ctrl", alu_ctrl, 4);
    chk("t1_srcA", src_A, 5);
    chk("t1_srcB", src_B, 7);
    nxt(); #1;
    chk("t1_valid", resp_valid, 1);
    chk("t1_result", resp_result, 12);
    chk("t1_id", resp_id, 0);
    chk("t1_flags", resp_flags, 4'h0);
    chk("t1_err", resp_err, 0);
    nxt(); #1;
    chk("t1_done", resp_valid, 0);

    // tie after reset: 0,1,0,1
    rst_n = 0; nxt();
    rst_n = 1;
    req0_valid = 1; req0_ctrl = 4'd4; req0_a = 1; req0_b = 1;
    req1_valid = 1; req1_ctrl = 4'd6; req1_a = 3; req1_b = 3;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("tie_rdy0", req0_ready, (i % 2) == 0);
      chk("tie_rdy1", req1_ready, (i % 2) == 1);
      nxt(); #1;
      chk("tie_exec_valid", resp_valid, 0);
      nxt(); #1;
      chk("tie_valid", resp_valid, 1);
      chk("tie_id", resp_id, i % 2);
      chk("tie_result", resp_result, (i % 2) ? 0 : 2);
      chk("tie_flags", resp_flags, (i % 2) ? 4'hA : 4'h0);
      nxt(); #1;
      chk("tie_flags_q", flags_q, (i % 2) ? 4'hA : 4'h0);
    end

    // backpressure, req1 waiting throughout
    req0_ctrl = 4'd4; req0_a = 32'h7FFF_FFFF; req0_b = 1;
    req1_ctrl = 4'd6; req1_a = 9; req1_b = 4;
    resp_ready = 0; #1;
    chk("bp_rdy0", req0_ready, 1);
    chk("bp_rdy1", req1_ready, 0);
    nxt(); req0_valid = 0; #1;
    chk("bp_exec_rdy1", req1_ready, 0);
    nxt(); #1;
    chk("bp_result", resp_result, 32'h8000_0000);
    chk("bp_flags", resp_flags, 4'h5);
    for (int i = 0; i < 5; i++) begin
      nxt(); #1;
      chk("bp_hold_valid", resp_valid, 1);
      chk("bp_hold_result", resp_result, 32'h8000_0000);
      chk("bp_hold_rdy1", req1_ready, 0);
      chk("bp_hold_flags_q", flags_q, 4'hA);
    end
    resp_ready = 1;
    nxt(); #1;
    chk("bp_flags_q", flags_q, 4'h5);
    chk("bp_valid_clr", resp_valid, 0);
    chk("bp_rdy1_next", req1_ready, 1);
    nxt(); req1_valid = 0;
    nxt(); #1;
    chk("bp_r1_id", resp_id, 1);
    chk("bp_r1_result", resp_result, 5);
    nxt(); #1;
    chk("bp_r1_flags_q", flags_q, 4'h2);

    // illegal op code
    req0_valid = 1; req0_ctrl = 4'd13; req0_a = 1; req0_b = 2; #1;
    chk("ill_rdy0", req0_ready, 1);
    nxt(); req0_valid = 0; #1;
    chk("ill_ctrl", alu_ctrl, 13);
    nxt(); #1;
    chk("ill_err", resp_err, 1);
    chk("ill_result", resp_result, 0);
    chk("ill_flags", resp_flags, 0);
    nxt(); #1;
    chk("ill_flags_q", flags_q, 4'h2);

    // reset during EXEC
    req0_valid = 1; req0_ctrl = 4'd4; req0_a = 5; req0_b = 7;
    nxt(); req1_valid = 1; rst_n = 0; #1;
    chk("rm_valid", resp_valid, 0);
    chk("rm_srcA", src_A, 0);
    chk("rm_ctrl", alu_ctrl, 0);
    chk("rm_flags_q", flags_q, 0);
    chk("rm_result", resp_result, 0);
    chk("rm_rdy0", req0_ready, 0);
    chk("rm_rdy1", req1_ready, 0);
    nxt(); rst_n = 1; #1;
    chk("rm_valid_after", resp_valid, 0);
    chk("rm_tie_rdy0", req0_ready, 1);
    chk("rm_tie_rdy1", req1_ready, 0);

    // three back-to-back ops
    for (int i = 0; i < 3; i++) begin
      nxt();
      if (i == 2) begin req0_valid = 0; req1_valid = 0; end
      nxt(); #1;
      chk("b2b_id", resp_id, i % 2);
      nxt();
    end
    nxt(); #1;
    chk("b2b_idle", resp_valid, 0);
`ifdef ALU_ARBITER_BUSY_CNT_EN
    chk("busy_cnt", busy_cnt, 6);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
